// File: rtl/rr_channel_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rr_channel_pkg
// Purpose  : Shared types and constants for the round-robin channel arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package rr_channel_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rr_pick
// Purpose  : Combinational round-robin search, starting at i_ptr and wrapping.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module rr_pick
  import rr_channel_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx
);

  always_comb begin
    int   k;
    logic found;
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      // Candidate index relative to the pointer, folded back into range.
      k = int'(i_ptr) + i;
      if (k >= N_REQ) begin
        k = k - N_REQ;
      end
      if (!found && i_req[k]) begin
        o_gnt[k] = 1'b1;
        o_idx    = IW'(k);
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_channel_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rr_channel_arbiter
// Purpose  : Round-robin arbiter loading one shared output register per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module rr_channel_arbiter
  import rr_channel_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0][W-1:0] i_data,
  output logic [N_REQ-1:0]        o_gnt,
  output logic                    o_valid,
  output logic [W-1:0]            o_data,
  output logic [$clog2(N_REQ)-1:0] o_owner,
  input  logic                    i_ready,
  output logic [CNT_W-1:0]        o_xfer_cnt
);

  localparam int IW = $clog2(N_REQ);

  chan_state_e      r_state;
  logic [IW-1:0]    r_ptr;
  logic [W-1:0]     r_data;
  logic [IW-1:0]    r_owner;
  logic [CNT_W-1:0] r_xfer_cnt;

  logic [N_REQ-1:0] w_pick_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_can_load;
  logic             w_grant;
  logic             w_xfer;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_idx)
  );

  // Reset is folded into the grant so o_gnt stays quiet while held in reset.
  assign w_can_load = (r_state == EMPTY) || i_ready;
  assign w_grant    = w_can_load && (|i_req) && i_rst_n;
  assign w_xfer     = (r_state == FULL) && i_ready;

  assign o_gnt      = w_grant ? w_pick_gnt : '0;
  assign o_valid    = (r_state == FULL);
  assign o_data     = r_data;
  assign o_owner    = r_owner;
  assign o_xfer_cnt = r_xfer_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= EMPTY;
      r_ptr      <= '0;
      r_data     <= '0;
      r_owner    <= '0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_state <= FULL;
        r_data  <= i_data[w_idx];
        r_owner <= w_idx;
        r_ptr   <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);
      end else if (w_xfer) begin
        r_state <= EMPTY;
      end
      if (w_xfer) begin
        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_channel_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_rr_channel_arbiter
// Purpose  : Directed bench for rr_channel_arbiter with a scoreboard of loaded words.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_rr_channel_arbiter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [3:0][7:0] data;
  logic            ready;
  logic [3:0]      gnt;
  logic            valid;
  logic [7:0]      odata;
  logic [1:0]      owner;
  logic [15:0]     xfer_cnt;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic        m_valid = 1'b0;
  logic [1:0]  m_ptr   = '0;
  logic [15:0] m_cnt   = '0;
  logic [7:0]  m_data  = '0;
  logic [1:0]  m_owner = '0;
  logic [9:0]  sb_q[$];
  logic [3:0]  last_gnt;

  rr_channel_arbiter #(.N_REQ(4), .W(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_data     (data),
    .o_gnt      (gnt),
    .o_valid    (valid),
    .o_data     (odata),
    .o_owner    (owner),
    .i_ready    (ready),
    .o_xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [3:0] r, input logic [1:0] p);
    for (int off = 0; off < 4; off++) begin
      int k;
      k = (int'(p) + off) % 4;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = '0;
    m_cnt   = '0;
    m_data  = '0;
    m_owner = '0;
    sb_q.delete();
  endtask

  // One cycle: inputs already driven; check mid-cycle, advance model, end just after posedge.
  task automatic cyc();
    int       k;
    logic [3:0] exp_gnt;
    logic     xfer;
    @(negedge clk);
    check("valid", valid, m_valid);
    check("xfer_cnt", xfer_cnt, m_cnt);
    check("data", odata, m_data);
    check("owner", owner, m_owner);
    if (m_valid) begin
      if (sb_q.size() == 0) check("sb_empty", 1, 0);
      else check("sb_word", {owner, odata}, sb_q[0]);
    end
    exp_gnt = '0;
    k = -1;
    if (rst_n && (!m_valid || ready)) begin
      k = model_pick(req, m_ptr);
      if (k >= 0) exp_gnt[k] = 1'b1;
    end
    check("gnt", gnt, exp_gnt);
    last_gnt = gnt;
    if (rst_n) begin
      xfer = m_valid && ready;
      if (xfer) begin
        m_cnt = m_cnt + 16'd1;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      if (k >= 0) begin
        m_data  = data[k];
        m_owner = 2'(k);
        m_ptr   = 2'((k + 1) % 4);
        m_valid = 1'b1;
        sb_q.push_back({2'(k), data[k]});
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    req   = 4'b1111;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) data[i] = 8'h10 + 8'(i);
    #1;
    check("async_rst_valid", valid, 0);

    // Held in reset with all requests asserted
    repeat (3) cyc();

    // Full round-robin sweep
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rr_seq", last_gnt, 4'b0001 << (i % 4));
      check("rr_data", odata, 8'h10 + 8'(i % 4));
    end

    // Drain, then single requester with stalled downstream
    req = 4'b0000;
    cyc();
    req   = 4'b0100;
    ready = 1'b0;
    cyc();
    check("stall_first_gnt", last_gnt, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("stall_gnt", last_gnt, 4'b0000);
      check("stall_data", odata, 8'h12);
    end

    // Wrap from requester 3 back to 0
    ready = 1'b1;
    req   = 4'b1000;
    cyc();
    check("gnt3", last_gnt, 4'b1000);
    req = 4'b1001;
    cyc();
    check("wrap_gnt0", last_gnt, 4'b0001);

    // Mixed traffic
    for (int i = 0; i < 40; i++) begin
      req   = 4'($urandom_range(0, 15));
      ready = 1'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++) data[j] = 8'($urandom);
      cyc();
    end

    // Drive the counter up to 0xFFFE
    req   = 4'b1111;
    ready = 1'b1;
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 70000) begin
      cyc();
      guard++;
    end
    check("preload", xfer_cnt, 16'hFFFE);
    cyc();
    check("cnt_ffff", xfer_cnt, 16'hFFFF);
    cyc();
    check("cnt_wrap", xfer_cnt, 16'h0000);
    cyc();
    check("cnt_0001", xfer_cnt, 16'h0001);

    // Asynchronous reset while FULL and stalled
    req   = 4'b0001;
    ready = 1'b0;
    cyc();
    req = 4'b0000;
    cyc();
    check("pre_rst_valid", valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_data", odata, 0);
    check("arst_owner", owner, 0);
    check("arst_cnt", xfer_cnt, 0);
    check("arst_gnt", gnt, 0);
    model_reset();
    req = 4'b1111;
    cyc();
    rst_n = 1'b1;
    ready = 1'b1;
    cyc();
    check("post_rst_gnt0", last_gnt, 4'b0001);
    check("post_rst_cnt", xfer_cnt, 0);
    cyc();
    check("post_rst_gnt1", last_gnt, 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
